// File: rtl/sp_sram_pipe.sv
// sp_sram_pipe: single-port SRAM with pipelined req/gnt, in-order
// response FIFO, rready backpressure and out-of-range detection.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   req_i, we_i        request valid, write (1) / read (0)
//   addr_i             word address
//   wdata_i, be_i      write data and byte enables
//   gnt_o, gntpar_o    request accepted when req_i & gnt_o; ~gnt_o
//   rvalid_o           response beat valid (FIFO not empty)
//   rvalidpar_o        ~rvalid_o
//   rready_i           response consumed when rvalid_o & rready_i
//   rdata_o            read data (zero for write and error beats)
//   rerr_o             beat belongs to an out-of-range access

module sp_sram_pipe #(
   parameter string INIT_FILE    = "",
   parameter int    DATA_WIDTH   = 32,
   parameter int    NUM_WORDS    = 1024,
   parameter int    READ_LATENCY = 1,
   localparam int   ADDR_WIDTH   = $clog2(NUM_WORDS),
   localparam int   BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   output logic                  gnt_o,
   output logic                  gntpar_o,
   output logic                  rvalid_o,
   output logic                  rvalidpar_o,
   input  logic                  rready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rerr_o
);

   localparam int RESP_DEPTH = READ_LATENCY + 1;
   localparam int CW         = $clog2(RESP_DEPTH + 1);
   localparam int PW         = $clog2(RESP_DEPTH);

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_dw
      $error("DATA_WIDTH must be a multiple of 8 in 8..128");
   end
   if (NUM_WORDS < 2) begin : g_bad_nw
      $error("NUM_WORDS must be at least 2");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_rl
      $error("READ_LATENCY must be in 1..4");
   end

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic                  accept;
   logic                  pop;
   logic                  push;
   logic                  in_range;
   logic [CW-1:0]         cnt;

   logic                  in_v;
   logic                  in_e;
   logic [DATA_WIDTH-1:0] in_d;
   logic                  out_v;
   logic                  out_e;
   logic [DATA_WIDTH-1:0] out_d;

   logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
   logic [RESP_DEPTH-1:0] fifo_err;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CW-1:0]         fcnt;

   initial begin
      for (int i = 0; i < NUM_WORDS; i++) begin
         mem[i] = '0;
      end
   end

   assign gnt_o    = rst_ni & (cnt < CW'(RESP_DEPTH));
   assign gntpar_o = ~gnt_o;
   assign accept   = req_i & gnt_o;
   assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH + 1)'(NUM_WORDS));

   always_ff @(posedge clk_i) begin
      if (accept && we_i && in_range) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (be_i[b]) begin
               mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      in_d = '0;
      if (accept && !we_i && in_range) begin
         in_d = mem[addr_i];
      end
   end

   assign in_v = accept;
   assign in_e = accept & ~in_range;

   if (READ_LATENCY == 1) begin : g_direct
      assign out_v = in_v;
      assign out_e = in_e;
      assign out_d = in_d;
   end else begin : g_pipe
      localparam int NS = READ_LATENCY - 1;

      logic [NS-1:0]         pv;
      logic [NS-1:0]         pe;
      logic [DATA_WIDTH-1:0] pd [NS];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < NS; i++) begin
               pd[i] <= '0;
            end
         end else begin
            pv[0] <= in_v;
            pe[0] <= in_e;
            pd[0] <= in_d;
            for (int i = 1; i < NS; i++) begin
               pv[i] <= pv[i-1];
               pe[i] <= pe[i-1];
               pd[i] <= pd[i-1];
            end
         end
      end

      assign out_v = pv[NS-1];
      assign out_e = pe[NS-1];
      assign out_d = pd[NS-1];
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push = out_v;
   assign pop  = rvalid_o & rready_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data[wptr] <= out_d;
         fifo_err[wptr]  <= out_e;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         fcnt <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            wptr <= ptr_inc(wptr);
         end
         if (pop) begin
            rptr <= ptr_inc(rptr);
         end
         case ({push, pop})
            2'b10:   fcnt <= fcnt + CW'(1);
            2'b01:   fcnt <= fcnt - CW'(1);
            default: fcnt <= fcnt;
         endcase
         case ({accept, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign rvalid_o    = rst_ni & (fcnt != '0);
   assign rvalidpar_o = ~rvalid_o;
   assign rdata_o     = rvalid_o ? fifo_data[rptr] : '0;
   assign rerr_o      = rvalid_o & fifo_err[rptr];

   a_no_overflow : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(push && !pop && fcnt == CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_sp_sram_pipe.sv
// tb_sp_sram_pipe: directed bench for sp_sram_pipe across three
// configurations selected by sel (RL=1/1000, RL=2/1000, RL=3/1024).

module tb_sp_sram_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic        rready = 1'b1;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;

   logic [2:0]  gnt_v, gntpar_v, rvalid_v, rvalidpar_v, rerr_v;
   logic [31:0] rdata0, rdata1, rdata2;

   logic        gnt, gntpar, rvalid, rvalidpar, rerr;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sp_sram_pipe #(.DATA_WIDTH(32), .NUM_WORDS(1000), .READ_LATENCY(1)) d0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req && sel == 2'd0), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_v[0]),
      .gntpar_o(gntpar_v[0]), .rvalid_o(rvalid_v[0]),
      .rvalidpar_o(rvalidpar_v[0]), .rready_i(rready),
      .rdata_o(rdata0), .rerr_o(rerr_v[0]));

   sp_sram_pipe #(.DATA_WIDTH(32), .NUM_WORDS(1000), .READ_LATENCY(2)) d1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req && sel == 2'd1), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_v[1]),
      .gntpar_o(gntpar_v[1]), .rvalid_o(rvalid_v[1]),
      .rvalidpar_o(rvalidpar_v[1]), .rready_i(rready),
      .rdata_o(rdata1), .rerr_o(rerr_v[1]));

   sp_sram_pipe #(.DATA_WIDTH(32), .NUM_WORDS(1024), .READ_LATENCY(3)) d2 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req && sel == 2'd2), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_v[2]),
      .gntpar_o(gntpar_v[2]), .rvalid_o(rvalid_v[2]),
      .rvalidpar_o(rvalidpar_v[2]), .rready_i(rready),
      .rdata_o(rdata2), .rerr_o(rerr_v[2]));

   assign gnt       = gnt_v[sel];
   assign gntpar    = gntpar_v[sel];
   assign rvalid    = rvalid_v[sel];
   assign rvalidpar = rvalidpar_v[sel];
   assign rerr      = rerr_v[sel];
   assign rdata     = (sel == 2'd0) ? rdata0 :
                      (sel == 2'd1) ? rdata1 : rdata2;

   typedef struct {
      logic        w;
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] xd;
      logic        xe;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_par();
      chk("gntpar", gntpar, !gnt);
      chk("rvalidpar", rvalidpar, !rvalid);
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(negedge clk);
      chk("send_gnt", gnt, 1'b1);
      @(posedge clk);
      #1 req = 1'b0;
   endtask

   // Expects the beat exactly lat cycles after the accept cycle.
   task automatic resp(input int lat, input logic [31:0] xd, input logic xe);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (i < lat - 1) begin
            chk("resp_early", rvalid, 1'b0);
         end else begin
            chk("resp_valid", rvalid, 1'b1);
            chk("resp_data", rdata, xd);
            chk("resp_err", rerr, xe);
            chk_par();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int beats;
      logic [31:0] bp_val [3];

      vt[0]  = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 10'd5,    32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 10'd3,    32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 10'd3,    32'h11223344, 4'h5, 32'h0,        1'b0};
      vt[4]  = '{1'b0, 10'd3,    32'h0,        4'h0, 32'hFF22FF44, 1'b0};
      vt[5]  = '{1'b1, 10'd7,    32'hAABBCCDD, 4'h0, 32'h0,        1'b0};
      vt[6]  = '{1'b0, 10'd7,    32'h0,        4'h0, 32'h0,        1'b0};
      vt[7]  = '{1'b1, 10'd999,  32'h12345678, 4'hF, 32'h0,        1'b0};
      vt[8]  = '{1'b1, 10'd1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
      vt[9]  = '{1'b0, 10'd1000, 32'h0,        4'h0, 32'h0,        1'b1};
      vt[10] = '{1'b0, 10'd999,  32'h0,        4'h0, 32'h12345678, 1'b0};
      vt[11] = '{1'b1, 10'd1023, 32'h55555555, 4'hF, 32'h0,        1'b1};
      vt[12] = '{1'b1, 10'd998,  32'h5A6B7C8D, 4'h8, 32'h0,        1'b0};
      vt[13] = '{1'b0, 10'd998,  32'h0,        4'h0, 32'h5A000000, 1'b0};

      // Reset held for three edges.
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt", gnt, 1'b0);
         chk("rst_gntpar", gntpar, 1'b1);
         chk("rst_rvalid", rvalid, 1'b0);
         chk("rst_rvalidpar", rvalidpar, 1'b1);
         chk("rst_rerr", rerr, 1'b0);
         chk("rst_rdata", rdata, 32'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", gnt, 1'b1);
      chk("post_rst_gntpar", gntpar, 1'b0);
      @(posedge clk);
      #1;

      // Table-driven single accesses on the RL=1 / 1000-word instance.
      sel = 2'd0;
      for (int i = 0; i < 14; i++) begin
         send(vt[i].w, vt[i].a, vt[i].d, vt[i].b);
         resp(1, vt[i].xd, vt[i].xe);
      end

      // Streaming on RL=3: preload, then 16 back-to-back reads.
      sel = 2'd2;
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 10'(i), 32'h1000 + i, 4'hF);
      end
      repeat (5) @(posedge clk);
      #1;
      beats = 0;
      for (int c = 0; c < 21; c++) begin
         req = (c < 16);
         we = 1'b0;
         addr = 10'(c);
         @(negedge clk);
         if (c < 16) chk("stream_gnt", gnt, 1'b1);
         chk("stream_valid", rvalid, (c >= 3 && c < 19));
         if (c >= 3 && c < 19) begin
            chk("stream_data", rdata, 32'h1000 + (c - 3));
            beats++;
         end
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      chk("stream_beats", beats, 16);

      // Backpressure on RL=2.
      sel = 2'd1;
      for (int i = 0; i < 3; i++) begin
         bp_val[i] = 32'hB0B00000 + 32'(i * 3 + 1);
         send(1'b1, 10'(20 + i), bp_val[i], 4'hF);
         resp(2, 32'h0, 1'b0);
      end
      rready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         req = 1'b1;
         we = 1'b0;
         addr = 10'(20 + acc);
         @(negedge clk);
         chk("bp_gnt", gnt, (c < 3));
         chk_par();
         if (gnt) acc++;
         if (c >= 2) begin
            chk("bp_valid", rvalid, 1'b1);
            chk("bp_stable", rdata, bp_val[0]);
         end
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      chk("bp_accepted", acc, 3);
      rready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         @(negedge clk);
         if (d < 3) begin
            chk("drain_valid", rvalid, 1'b1);
            chk("drain_data", rdata, bp_val[d]);
            chk("drain_gnt", gnt, (d > 0));
         end else begin
            chk("drain_empty", rvalid, 1'b0);
         end
         @(posedge clk);
         #1;
      end

      // Reset with two buffered responses on RL=1.
      sel = 2'd0;
      send(1'b1, 10'd40, 32'h0BADF00D, 4'hF);
      resp(1, 32'h0, 1'b0);
      rready = 1'b0;
      send(1'b0, 10'd40, 32'h0, 4'h0);
      send(1'b0, 10'd40, 32'h0, 4'h0);
      @(negedge clk);
      chk("mid_full_valid", rvalid, 1'b1);
      chk("mid_full_gnt", gnt, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      req = 1'b1; we = 1'b1; addr = 10'd40;
      wdata = 32'hFFFFFFFF; be = 4'hF;
      @(negedge clk);
      chk("mid_rst_valid", rvalid, 1'b0);
      chk("mid_rst_gnt", gnt, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req = 1'b0;
      rready = 1'b1;
      @(negedge clk);
      chk("mid_post_gnt", gnt, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_stale", rvalid, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send(1'b0, 10'd40, 32'h0, 4'h0);
      resp(1, 32'h0BADF00D, 1'b0);

      // Reset while a read is inside the RL=3 pipeline.
      sel = 2'd2;
      send(1'b0, 10'd5, 32'h0, 4'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("pipe_flush", rvalid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(1'b0, 10'd5, 32'h0, 4'h0);
      resp(3, 32'h1005, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
